concat_scheduler: RTL

- Layer-level sequencer for the concat datapath.
- Takes one host start command and a block count, then launches the concat datapath once per row block: Start_Concat for the first block, Next_Reg for each later block.
- Advances to the next block only when the datapath has signalled Last_Concat and the write DMA has signalled completion of that block.
- Counts output beats per block, checks them against the expected count, and runs a watchdog. Sits between the host register file and the concat top.

---
 rtl/concat_scheduler_if.sv | 39 +++
 rtl/concat_scheduler.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/concat_scheduler_if.sv
// Host/datapath/DMA signal bundle around the concat layer sequencer.
// The master side is the surrounding system; the slave side is the scheduler.
interface concat_scheduler_if #(
  parameter int BLK_W  = 12,
  parameter int BEAT_W = 20,
  parameter int TMO_W  = 24
);
  logic              Start;
  logic [BLK_W-1:0]  Cfg_Block_Num;
  logic [BEAT_W-1:0] Cfg_Beats_Per_Block;
  logic [TMO_W-1:0]  Cfg_Timeout;
  logic              Last_Concat;
  logic              Dma_Wr_Done;
  logic              M_Valid;
  logic              M_Ready;
  logic              Start_Concat;
  logic              Next_Reg;
  logic              Write_Block_Complete;
  logic [BLK_W-1:0]  Block_Idx;
  logic              Busy;
  logic              Done;
  logic              Beat_Err;
  logic              Timeout_Err;
  logic [BEAT_W-1:0] Beat_Count;

  modport master (
    output Start, Cfg_Block_Num, Cfg_Beats_Per_Block, Cfg_Timeout,
           Last_Concat, Dma_Wr_Done, M_Valid, M_Ready,
    input  Start_Concat, Next_Reg, Write_Block_Complete, Block_Idx,
           Busy, Done, Beat_Err, Timeout_Err, Beat_Count
  );

  modport slave (
    input  Start, Cfg_Block_Num, Cfg_Beats_Per_Block, Cfg_Timeout,
           Last_Concat, Dma_Wr_Done, M_Valid, M_Ready,
    output Start_Concat, Next_Reg, Write_Block_Complete, Block_Idx,
           Busy, Done, Beat_Err, Timeout_Err, Beat_Count
  );
endinterface

// File: rtl/concat_scheduler.sv
// Layer-level sequencer: launches the concat datapath once per row block,
// waits for datapath end and DMA completion, checks beats, runs a watchdog.
module concat_scheduler #(
  parameter int BLK_W  = 12,
  parameter int BEAT_W = 20,
  parameter int TMO_W  = 24
) (
  input  logic                clk,
  input  logic                rst,
  concat_scheduler_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_RUN    = 3'd2,
    S_CLOSE  = 3'd3,
    S_FIN    = 3'd4
  } state_t;

  state_t            state_r, next_state_s;
  logic [BLK_W-1:0]  blk_num_r, block_idx_r;
  logic [BEAT_W-1:0] beats_cfg_r, beat_count_r;
  logic [TMO_W-1:0]  tmo_cfg_r, wdog_r;
  logic              last_seen_r, wr_seen_r;
  logic              start_concat_r, next_reg_r, wbc_r, busy_r, done_r;
  logic              beat_err_r, timeout_err_r;
  logic              block_done_s, wdog_fire_s, last_block_s;

  // Block completion, watchdog expiry and last-block detection
  always_comb begin
    block_done_s = (last_seen_r | bus.Last_Concat) & (wr_seen_r | bus.Dma_Wr_Done);
    // Widened compare so a saturated counter still reaches an all-ones limit
    wdog_fire_s  = (tmo_cfg_r != {TMO_W{1'b0}}) &&
                   (({1'b0, wdog_r} + {{TMO_W{1'b0}}, 1'b1}) >= {1'b0, tmo_cfg_r});
    last_block_s = (block_idx_r == (blk_num_r - {{(BLK_W-1){1'b0}}, 1'b1}));
  end

  // Next-state decode
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (bus.Start) begin
          next_state_s = (bus.Cfg_Block_Num == {BLK_W{1'b0}}) ? S_FIN : S_LAUNCH;
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_LAUNCH: next_state_s = S_RUN;
      S_RUN: begin
        // A block that finishes on the expiry cycle is allowed to close
        if (block_done_s) begin
          next_state_s = S_CLOSE;
        end else if (wdog_fire_s) begin
          next_state_s = S_IDLE;
        end else begin
          next_state_s = S_RUN;
        end
      end
      S_CLOSE: next_state_s = last_block_s ? S_FIN : S_LAUNCH;
      S_FIN:   next_state_s = S_IDLE;
      default: next_state_s = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Registered pulses, configuration latches, counters and sticky errors
  always_ff @(posedge clk) begin
    if (rst) begin
      start_concat_r <= 1'b0;
      next_reg_r     <= 1'b0;
      wbc_r          <= 1'b0;
      done_r         <= 1'b0;
      busy_r         <= 1'b0;
      beat_err_r     <= 1'b0;
      timeout_err_r  <= 1'b0;
      blk_num_r      <= {BLK_W{1'b0}};
      block_idx_r    <= {BLK_W{1'b0}};
      beats_cfg_r    <= {BEAT_W{1'b0}};
      beat_count_r   <= {BEAT_W{1'b0}};
      tmo_cfg_r      <= {TMO_W{1'b0}};
      wdog_r         <= {TMO_W{1'b0}};
      last_seen_r    <= 1'b0;
      wr_seen_r      <= 1'b0;
    end else begin
      // Pulses are decoded from the next state so they line up with it
      start_concat_r <= (state_r == S_IDLE)  && (next_state_s == S_LAUNCH);
      next_reg_r     <= (state_r == S_CLOSE) && (next_state_s == S_LAUNCH);
      wbc_r          <= (next_state_s == S_CLOSE);
      done_r         <= (next_state_s == S_FIN);
      busy_r         <= (next_state_s != S_IDLE);
      case (state_r)
        S_IDLE: begin
          if (bus.Start) begin
            blk_num_r     <= bus.Cfg_Block_Num;
            beats_cfg_r   <= bus.Cfg_Beats_Per_Block;
            tmo_cfg_r     <= bus.Cfg_Timeout;
            beat_err_r    <= 1'b0;
            timeout_err_r <= 1'b0;
            block_idx_r   <= {BLK_W{1'b0}};
            beat_count_r  <= {BEAT_W{1'b0}};
            wdog_r        <= {TMO_W{1'b0}};
            last_seen_r   <= 1'b0;
            wr_seen_r     <= 1'b0;
          end
        end
        S_LAUNCH: begin
          beat_count_r <= {BEAT_W{1'b0}};
          wdog_r       <= {TMO_W{1'b0}};
          last_seen_r  <= 1'b0;
          wr_seen_r    <= 1'b0;
        end
        S_RUN: begin
          if (bus.Last_Concat) last_seen_r <= 1'b1;
          if (bus.Dma_Wr_Done) wr_seen_r   <= 1'b1;
          if (bus.M_Valid && bus.M_Ready && (beat_count_r != {BEAT_W{1'b1}})) begin
            beat_count_r <= beat_count_r + {{(BEAT_W-1){1'b0}}, 1'b1};
          end
          if (wdog_r != {TMO_W{1'b1}}) begin
            wdog_r <= wdog_r + {{(TMO_W-1){1'b0}}, 1'b1};
          end
          if (wdog_fire_s && !block_done_s) timeout_err_r <= 1'b1;
        end
        S_CLOSE: begin
          if (beat_count_r != beats_cfg_r) beat_err_r <= 1'b1;
          if (!last_block_s) block_idx_r <= block_idx_r + {{(BLK_W-1){1'b0}}, 1'b1};
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.Start_Concat         = start_concat_r;
  assign bus.Next_Reg             = next_reg_r;
  assign bus.Write_Block_Complete = wbc_r;
  assign bus.Block_Idx            = block_idx_r;
  assign bus.Busy                 = busy_r;
  assign bus.Done                 = done_r;
  assign bus.Beat_Err             = beat_err_r;
  assign bus.Timeout_Err          = timeout_err_r;
  assign bus.Beat_Count           = beat_count_r;

endmodule
